// File: rtl/sfp_ctrl_pkg.sv
// ============================================================================
// Module   : sfp_ctrl_pkg
// Brief    : Shared FSM state encoding and default widths for sfp_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sfp_ctrl_pkg;

    localparam int c_bw      = 8;
    localparam int c_psum_bw = 16;
    localparam int c_addr_bw = 4;

    localparam int c_st_w = 3;
    localparam logic [c_st_w-1:0] c_st_idle    = 3'd0;
    localparam logic [c_st_w-1:0] c_st_run     = 3'd1;
    localparam logic [c_st_w-1:0] c_st_relu    = 3'd2;
    localparam logic [c_st_w-1:0] c_st_wait    = 3'd3;
    localparam logic [c_st_w-1:0] c_st_capture = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sfp_ctrl.sv
// ============================================================================
// Module   : sfp_ctrl
// Brief    : Streams len words from memory into sfp (acc), applies one relu,
//            then captures the sfp result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sfp_ctrl
    import sfp_ctrl_pkg::*;
#(
    parameter int bw      = c_bw,
    parameter int psum_bw = c_psum_bw,
    parameter int addr_bw = c_addr_bw
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] len,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [psum_bw-1:0] thres_cfg,
    output logic               mem_rd,
    output logic [addr_bw-1:0] mem_addr,
    input  logic [bw-1:0]      mem_rdata,
    output logic [bw-1:0]      sfp_in,
    output logic               sfp_acc,
    output logic               sfp_relu,
    output logic [psum_bw-1:0] sfp_thres,
    input  logic [psum_bw-1:0] sfp_out,
    output logic               busy,
    output logic               res_valid,
    output logic [psum_bw-1:0] res_data
);

    logic [c_st_w-1:0]  r_state, w_next_state;
    logic               w_accept;
    logic [addr_bw-1:0] r_len, r_base;
    logic [addr_bw:0]   r_cnt, w_cnt_inc, w_len_ext;

    logic               r_mem_rd, w_mem_rd;
    logic [addr_bw-1:0] r_mem_addr, w_mem_addr;
    logic               r_acc, w_acc;
    logic               r_relu, w_relu;
    logic [psum_bw-1:0] r_thres;
    logic               r_busy;
    logic               r_res_valid, w_res_valid;
    logic [psum_bw-1:0] r_res_data, w_res_data;

    assign w_accept  = (r_state == c_st_idle) && start && (len != '0);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_len_ext = {1'b0, r_len};

    // State, counter, latched config and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_len       <= '0;
            r_base      <= '0;
            r_cnt       <= '0;
            r_thres     <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_acc       <= 1'b0;
            r_relu      <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_len   <= len;
                r_base  <= base_addr;
                r_thres <= thres_cfg;
                r_cnt   <= '0;
            end else if (r_state == c_st_run) begin
                r_cnt <= w_cnt_inc;
            end
            r_mem_rd    <= w_mem_rd;
            r_mem_addr  <= w_mem_addr;
            r_acc       <= w_acc;
            r_relu      <= w_relu;
            r_busy      <= (w_next_state != c_st_idle);
            r_res_valid <= w_res_valid;
            r_res_data  <= w_res_data;
        end
    end

    // RUN spans len read cycles plus the trailing acc cycle of the last word
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    if (w_accept) w_next_state = c_st_run;
            c_st_run:     if (r_cnt == w_len_ext) w_next_state = c_st_relu;
            c_st_relu:    w_next_state = c_st_wait;
            c_st_wait:    w_next_state = c_st_capture;
            c_st_capture: w_next_state = c_st_idle;
            default:      w_next_state = c_st_idle;
        endcase
    end

    // Next values of the registered outputs, one cycle ahead of the bus
    always_comb begin
        w_mem_rd    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_acc       = 1'b0;
        w_relu      = 1'b0;
        w_res_valid = 1'b0;
        w_res_data  = r_res_data;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_mem_rd   = 1'b1;
                    w_mem_addr = base_addr;
                end
            end
            c_st_run: begin
                w_mem_rd   = (w_cnt_inc < w_len_ext);
                w_mem_addr = r_base + w_cnt_inc[addr_bw-1:0];
                w_acc      = (r_cnt < w_len_ext);
                w_relu     = (r_cnt == w_len_ext);
            end
            c_st_wait: begin
                w_res_valid = 1'b1;
                w_res_data  = sfp_out;
            end
            default: ;
        endcase
    end

    // Read data lands the cycle after the read; gate it so sfp_in is 0 off-window
    assign sfp_in    = r_acc ? mem_rdata : '0;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;
    assign sfp_acc   = r_acc;
    assign sfp_relu  = r_relu;
    assign sfp_thres = r_thres;
    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

`default_nettype wire

// File: tb/tb_sfp_ctrl.sv
// ============================================================================
// Module   : tb_sfp_ctrl
// Brief    : Self-checking bench for sfp_ctrl with memory and sfp models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sfp_ctrl;

    localparam int c_bw = 8;
    localparam int c_pw = 16;
    localparam int c_aw = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [c_aw-1:0] len = '0;
    logic [c_aw-1:0] base_addr = '0;
    logic [c_pw-1:0] thres_cfg = '0;
    logic            mem_rd;
    logic [c_aw-1:0] mem_addr;
    logic [c_bw-1:0] mem_rdata;
    logic [c_bw-1:0] sfp_in;
    logic            sfp_acc;
    logic            sfp_relu;
    logic [c_pw-1:0] sfp_thres;
    logic [c_pw-1:0] sfp_out;
    logic            busy;
    logic            res_valid;
    logic [c_pw-1:0] res_data;

    logic [c_bw-1:0] mem [16];
    int checks = 0;
    int errors = 0;

    sfp_ctrl #(.bw(c_bw), .psum_bw(c_pw), .addr_bw(c_aw)) u_dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .base_addr(base_addr), .thres_cfg(thres_cfg),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .sfp_in(sfp_in), .sfp_acc(sfp_acc), .sfp_relu(sfp_relu),
        .sfp_thres(sfp_thres), .sfp_out(sfp_out),
        .busy(busy), .res_valid(res_valid), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data one cycle after mem_rd
    always @(posedge clk) begin
        if (reset) mem_rdata <= '0;
        else       mem_rdata <= mem_rd ? mem[mem_addr] : '0;
    end

    // Behavioural sfp: accumulate, threshold-relu, cleared once a result is taken
    always @(posedge clk) begin
        if (reset || res_valid)  sfp_out <= '0;
        else if (sfp_acc)        sfp_out <= sfp_out + c_pw'(sfp_in);
        else if (sfp_relu)       sfp_out <= (sfp_out > sfp_thres) ? sfp_out : '0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_mem_rd"},    32'(mem_rd),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_sfp_in"},    32'(sfp_in),    32'd0);
        chk({tag, "_sfp_acc"},   32'(sfp_acc),   32'd0);
        chk({tag, "_sfp_relu"},  32'(sfp_relu),  32'd0);
        chk({tag, "_sfp_thres"}, 32'(sfp_thres), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(res_data),  32'd0);
    endtask

    task automatic fill_mem_random();
        for (int i = 0; i < 16; i++) mem[i] = c_bw'($urandom);
    endtask

    // One job checked against its cycle timeline; cycle c counts edges after acceptance.
    // hold keeps start high throughout, poke re-pulses start at cycle poke, abort resets at cycle abort.
    task automatic job(input int n, input int b, input int th, input bit hold,
                       input int poke, input int abort);
        int              sum;
        logic [c_pw-1:0] expres;
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(mem[(b + i) % 16]);
        expres = (sum > th) ? c_pw'(sum) : '0;
        start     = 1'b1;
        len       = c_aw'(n);
        base_addr = c_aw'(b);
        thres_cfg = c_pw'(th);
        for (int c = 1; c <= n + 5; c++) begin
            @(negedge clk);
            if (!hold) begin
                start = (c == poke);
                if (c == 1) begin
                    len       = c_aw'($urandom);
                    base_addr = c_aw'($urandom);
                    thres_cfg = c_pw'($urandom);
                end
            end
            if (c == abort) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk_idle_zero("abort");
                reset = 1'b0;
                return;
            end
            chk("mem_rd", 32'(mem_rd), 32'(c <= n));
            if (c <= n) chk("mem_addr", 32'(mem_addr), 32'((b + c - 1) % 16));
            chk("sfp_acc", 32'(sfp_acc), 32'(c >= 2 && c <= n + 1));
            if (c >= 2 && c <= n + 1) chk("sfp_in", 32'(sfp_in), 32'(mem[(b + c - 2) % 16]));
            chk("sfp_relu", 32'(sfp_relu), 32'(c == n + 2));
            chk("busy", 32'(busy), 32'(c <= n + 4));
            chk("res_valid", 32'(res_valid), 32'(c == n + 4));
            chk("sfp_thres", 32'(sfp_thres), 32'(th));
            if (c == n + 4) chk("res_eq_sfp_out", 32'(res_data), 32'(sfp_out));
            if (c >= n + 4) chk("res_data", 32'(res_data), 32'(expres));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = c_bw'(i + 1);
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        reset = 1'b0;

        // words 1..10, sum 55 is below threshold 64
        job(10, 0, 64, 1'b0, 0, 0);
        job(10, 0, 40, 1'b0, 0, 0);

        // address wrap 14,15,0
        job(3, 14, 0, 1'b0, 0, 0);

        // len==0 must be ignored
        start = 1'b1;
        len   = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("len0_busy", 32'(busy), 32'd0);
            chk("len0_mem_rd", 32'(mem_rd), 32'd0);
            chk("len0_res_valid", 32'(res_valid), 32'd0);
        end

        // start during RUN ignored, then a later job runs normally
        job(6, 3, 10, 1'b0, 3, 0);
        job(4, 9, 5, 1'b0, 0, 0);

        // reset on third RUN cycle, then first start accepted
        job(8, 2, 0, 1'b0, 0, 3);
        job(5, 1, 7, 1'b0, 0, 0);

        // back-to-back with start held high: one job every 7 cycles
        job(2, 5, 3, 1'b1, 0, 0);
        job(2, 5, 3, 1'b1, 0, 0);
        job(2, 7, 0, 1'b1, 0, 0);
        job(2, 7, 0, 1'b0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            int n;
            int b;
            int th;
            int poke;
            fill_mem_random();
            n    = int'($urandom_range(1, 15));
            b    = int'($urandom_range(0, 15));
            th   = int'($urandom_range(0, 1500));
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, n + 3)) : 0;
            job(n, b, th, 1'b0, poke, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
